// File: rtl/if_id_queue_if.sv
// Handshake bundle between instruction fetch, the IF/ID queue and decode.
// The master modport is the environment side: fetch and decode together.
// The slave modport is the queue itself.
interface if_id_queue_if #(
  parameter int XLEN = 32
);
  logic            f_valid;
  logic [XLEN-1:0] f_pc;
  logic [XLEN-1:0] f_instr;
  logic            f_ready;
  logic            flush;
  logic            d_valid;
  logic [XLEN-1:0] d_pc;
  logic [XLEN-1:0] d_instr;
  logic            d_misaligned;
  logic            d_ready;

  modport master (
    output f_valid, f_pc, f_instr, flush, d_ready,
    input  f_ready, d_valid, d_pc, d_instr, d_misaligned
  );

  modport slave (
    input  f_valid, f_pc, f_instr, flush, d_ready,
    output f_ready, d_valid, d_pc, d_instr, d_misaligned
  );
endinterface

// File: rtl/if_id_queue.sv
// IF/ID instruction queue: a circular FIFO of {pc, instr, misaligned} entries.
// It decouples fetch from decode stalls, and a taken-branch flush discards
// every buffered entry.
// Optional macro IF_ID_QUEUE_PERF_EN adds three saturating 32-bit
// performance counters: full stalls, decode bubbles and flushed entries.
module if_id_queue #(
  parameter int DEPTH = 2,
  parameter int XLEN  = 32
) (
  input  logic        clk,
  input  logic        reset_n,
  if_id_queue_if.slave bus
`ifdef IF_ID_QUEUE_PERF_EN
  ,
  output logic [31:0] stall_full_cnt,
  output logic [31:0] bubble_cnt,
  output logic [31:0] flushed_cnt
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [XLEN-1:0] pc_mem    [DEPTH];
  logic [XLEN-1:0] instr_mem [DEPTH];
  logic            mis_mem   [DEPTH];

  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          push, pop;

  // Handshake decode: both ready/valid outputs come only from the registered
  // count, so there is no combinational path from any input to any output.
  assign bus.f_ready = (count_q != FULL_CNT);
  assign bus.d_valid = (count_q != '0);
  assign push = bus.f_valid & bus.f_ready & ~bus.flush;
  assign pop  = bus.d_valid & bus.d_ready & ~bus.flush;

  // The head entry is forced to zero while empty so stale storage never leaks.
  assign bus.d_pc         = bus.d_valid ? pc_mem[rd_ptr_q]    : '0;
  assign bus.d_instr      = bus.d_valid ? instr_mem[rd_ptr_q] : '0;
  assign bus.d_misaligned = bus.d_valid ? mis_mem[rd_ptr_q]   : 1'b0;

  // Next-state for the pointers and occupancy; flush overrides everything.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (bus.flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + (AW+1)'(1);
        2'b01:   count_d = count_q - (AW+1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Control state register with asynchronous clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; written only on an accepted push and never reset.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr_q]    <= bus.f_pc;
      instr_mem[wr_ptr_q] <= bus.f_instr;
      mis_mem[wr_ptr_q]   <= |bus.f_pc[1:0];
    end
  end

`ifdef IF_ID_QUEUE_PERF_EN
  logic [31:0] stall_full_cnt_q, stall_full_cnt_d;
  logic [31:0] bubble_cnt_q, bubble_cnt_d;
  logic [31:0] flushed_cnt_q, flushed_cnt_d;
  logic [32:0] flushed_sum;

  // Saturating counter updates; flushed entries add the occupancy at the flush.
  always_comb begin
    stall_full_cnt_d = stall_full_cnt_q;
    bubble_cnt_d     = bubble_cnt_q;
    flushed_cnt_d    = flushed_cnt_q;
    flushed_sum      = {1'b0, flushed_cnt_q} + 33'(count_q);
    if (bus.f_valid && !bus.f_ready && (stall_full_cnt_q != '1))
      stall_full_cnt_d = stall_full_cnt_q + 32'd1;
    if (bus.d_ready && !bus.d_valid && (bubble_cnt_q != '1))
      bubble_cnt_d = bubble_cnt_q + 32'd1;
    if (bus.flush)
      flushed_cnt_d = flushed_sum[32] ? '1 : flushed_sum[31:0];
  end

  // Counters are cleared by reset only, never by flush.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_full_cnt_q <= '0;
      bubble_cnt_q     <= '0;
      flushed_cnt_q    <= '0;
    end else begin
      stall_full_cnt_q <= stall_full_cnt_d;
      bubble_cnt_q     <= bubble_cnt_d;
      flushed_cnt_q    <= flushed_cnt_d;
    end
  end

  assign stall_full_cnt = stall_full_cnt_q;
  assign bubble_cnt     = bubble_cnt_q;
  assign flushed_cnt    = flushed_cnt_q;
`endif

endmodule

// File: tb/tb_if_id_queue.sv
// Self-checking bench for if_id_queue (DEPTH = 2, XLEN = 32).
// A queue-based reference model tracks the buffered pairs and is compared
// with the DUT outputs on every falling edge; directed sequences add literal
// expectations for delivery order, flush, misalignment and async reset.
module tb_if_id_queue;
  localparam int DEPTH = 2;
  localparam int XLEN  = 32;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } entry_t;

  logic clk = 1'b0;
  logic reset_n;
  if_id_queue_if #(.XLEN(XLEN)) bus ();

`ifdef IF_ID_QUEUE_PERF_EN
  logic [31:0] stall_full_cnt, bubble_cnt, flushed_cnt;
`endif

  if_id_queue #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
`ifdef IF_ID_QUEUE_PERF_EN
    ,
    .stall_full_cnt (stall_full_cnt),
    .bubble_cnt     (bubble_cnt),
    .flushed_cnt    (flushed_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  entry_t          mq[$];
  logic [XLEN-1:0] delivered[$];
  longint          m_stall, m_bubble, m_flushed;

  function automatic logic [XLEN-1:0] instr_of(input logic [XLEN-1:0] pc);
    return 32'h0000_0013 + (pc << 8);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
  endtask

  // Reference model: the queue contents follow the accepted pushes and pops.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mq.delete();
      m_stall   = 0;
      m_bubble  = 0;
      m_flushed = 0;
    end else begin
      automatic bit fr = (mq.size() != DEPTH);
      automatic bit dv = (mq.size() != 0);
      if (bus.f_valid && !fr) m_stall++;
      if (bus.d_ready && !dv) m_bubble++;
      if (bus.d_valid && bus.d_ready && !bus.flush) delivered.push_back(bus.d_pc);
      if (bus.flush) begin
        m_flushed += mq.size();
        mq.delete();
      end else begin
        if (dv && bus.d_ready) void'(mq.pop_front());
        if (bus.f_valid && fr) mq.push_back('{pc: bus.f_pc, instr: bus.f_instr});
      end
    end
  end

  // Every-cycle comparison of the DUT against the model.
  always @(negedge clk) begin
    automatic bit empty = (mq.size() == 0);
    check("m_d_valid", {31'd0, bus.d_valid}, {31'd0, !empty});
    check("m_f_ready", {31'd0, bus.f_ready}, {31'd0, mq.size() != DEPTH});
    check("m_d_pc", bus.d_pc, empty ? 32'd0 : mq[0].pc);
    check("m_d_instr", bus.d_instr, empty ? 32'd0 : mq[0].instr);
    check("m_d_mis", {31'd0, bus.d_misaligned}, {31'd0, empty ? 1'b0 : |mq[0].pc[1:0]});
`ifdef IF_ID_QUEUE_PERF_EN
    check("m_stall_cnt", stall_full_cnt, 32'(m_stall));
    check("m_bubble_cnt", bubble_cnt, 32'(m_bubble));
    check("m_flushed_cnt", flushed_cnt, 32'(m_flushed));
`endif
  end

  // Apply one cycle of inputs; returns just after the next falling edge.
  task automatic drive(input logic fv, input logic [XLEN-1:0] pc, input logic dr, input logic fl);
    bus.f_valid = fv;
    bus.f_pc    = pc;
    bus.f_instr = instr_of(pc);
    bus.d_ready = dr;
    bus.flush   = fl;
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int hits;
    bus.f_valid = 1'b0;
    bus.f_pc    = '0;
    bus.f_instr = '0;
    bus.d_ready = 1'b0;
    bus.flush   = 1'b0;
    do_reset();
    check("rst_d_valid", {31'd0, bus.d_valid}, 32'd0);
    check("rst_f_ready", {31'd0, bus.f_ready}, 32'd1);
    check("rst_d_pc", bus.d_pc, 32'd0);

    // 1: streaming with decode always ready
    delivered.delete();
    drive(1'b1, 32'h0, 1'b1, 1'b0);
    check("t1_pc0", bus.d_pc, 32'h0);
    check("t1_v0", {31'd0, bus.d_valid}, 32'd1);
    check("t1_instr0", bus.d_instr, 32'h13);
    drive(1'b1, 32'h4, 1'b1, 1'b0);
    check("t1_pc4", bus.d_pc, 32'h4);
    drive(1'b1, 32'h8, 1'b1, 1'b0);
    check("t1_pc8", bus.d_pc, 32'h8);
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    check("t1_empty", {31'd0, bus.d_valid}, 32'd0);
    check("t1_n", delivered.size(), 32'd3);
    check("t1_seq1", delivered[1], 32'h4);

    // 2: fill to full while decode stalls, then drain
    delivered.delete();
    drive(1'b1, 32'h10, 1'b0, 1'b0);
    drive(1'b1, 32'h14, 1'b0, 1'b0);
    check("t2_full", {31'd0, bus.f_ready}, 32'd0);
    drive(1'b1, 32'h18, 1'b0, 1'b0);
    drive(1'b1, 32'h18, 1'b0, 1'b0);
    check("t2_head", bus.d_pc, 32'h10);
    drive(1'b1, 32'h18, 1'b1, 1'b0);
    drive(1'b1, 32'h18, 1'b1, 1'b0);
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    check("t2_n", delivered.size(), 32'd3);
    check("t2_seq0", delivered[0], 32'h10);
    check("t2_seq1", delivered[1], 32'h14);
    check("t2_seq2", delivered[2], 32'h18);
    check("t2_empty", {31'd0, bus.d_valid}, 32'd0);

    // 3: flush discards buffered entries and the pair presented with it
    delivered.delete();
    drive(1'b1, 32'h20, 1'b0, 1'b0);
    drive(1'b1, 32'h24, 1'b0, 1'b0);
    drive(1'b1, 32'h28, 1'b0, 1'b1);
    check("t3_flush_v", {31'd0, bus.d_valid}, 32'd0);
    check("t3_flush_fr", {31'd0, bus.f_ready}, 32'd1);
    drive(1'b1, 32'h100, 1'b0, 1'b0);
    check("t3_next", bus.d_pc, 32'h100);
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    hits = 0;
    foreach (delivered[i]) if (delivered[i] == 32'h28) hits++;
    check("t3_no28", hits, 32'd0);
    check("t3_n", delivered.size(), 32'd1);

    // 4: misaligned flag captured at push
    drive(1'b1, 32'h32, 1'b1, 1'b0);
    check("t4_mis1", {31'd0, bus.d_misaligned}, 32'd1);
    drive(1'b1, 32'h34, 1'b1, 1'b0);
    check("t4_pc34", bus.d_pc, 32'h34);
    check("t4_mis0", {31'd0, bus.d_misaligned}, 32'd0);
    drive(1'b0, 32'h0, 1'b1, 1'b0);

    // 5: asynchronous reset while full
    drive(1'b1, 32'h40, 1'b0, 1'b0);
    drive(1'b1, 32'h44, 1'b0, 1'b0);
    check("t5_full", {31'd0, bus.f_ready}, 32'd0);
    bus.f_valid = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    check("t5_v", {31'd0, bus.d_valid}, 32'd0);
    check("t5_pc", bus.d_pc, 32'd0);
    check("t5_instr", bus.d_instr, 32'd0);
    check("t5_fr", {31'd0, bus.f_ready}, 32'd1);
    @(negedge clk);
    #1;
    reset_n = 1'b1;
    drive(1'b1, 32'h200, 1'b0, 1'b0);
    check("t5_after", bus.d_pc, 32'h200);
    check("t5_after_i", bus.d_instr, 32'h0002_0013);
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    check("t5_drain", {31'd0, bus.d_valid}, 32'd0);

`ifdef IF_ID_QUEUE_PERF_EN
    // 6: performance counters from a clean reset
    do_reset();
    drive(1'b1, 32'h300, 1'b0, 1'b0);
    drive(1'b1, 32'h304, 1'b0, 1'b0);
    drive(1'b1, 32'h308, 1'b0, 1'b0);
    drive(1'b1, 32'h308, 1'b0, 1'b0);
    drive(1'b1, 32'h308, 1'b0, 1'b0);
    drive(1'b0, 32'h0, 1'b0, 1'b1);
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    check("t6_stall", stall_full_cnt, 32'd3);
    check("t6_bubble", bubble_cnt, 32'd2);
    check("t6_flushed", flushed_cnt, 32'd2);
`endif

    drive(1'b0, 32'h0, 1'b0, 1'b0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/if_id_queue.md
Name: if_id_queue

Overview:
- Instruction queue between the instruction fetch unit and the decode stage.
- Buffers fetched {pc, instruction} pairs in a small circular FIFO with valid/ready handshakes on both sides.
- Decouples fetch from decode stalls.
- Discards every buffered entry when a taken branch redirects fetch.

Parameters:
- DEPTH, 2: number of queue entries; power of two, 2 to 16.
- XLEN, 32: width of pc and instruction.

Ports:
- clk  input  1  rising-edge clock.
- reset_n  input  1  asynchronous active-low reset.
- f_valid  input  1  fetch presents a valid pc/instruction pair.
- f_pc  input  XLEN  pc of the fetched instruction.
- f_instr  input  XLEN  fetched instruction word.
- f_ready  output  1  queue accepts a push this cycle.
- flush  input  1  taken-branch redirect; driven by the same signal as fetch's branch_taken.
- d_valid  output  1  head entry is valid for decode.
- d_pc  output  XLEN  pc of the head entry.
- d_instr  output  XLEN  instruction of the head entry.
- d_misaligned  output  1  head entry pc had bits [1:0] != 0 when pushed.
- d_ready  input  1  decode consumes the head this cycle.

Behaviour:
- Storage: DEPTH entries of {pc, instr, misaligned}. Read pointer and write pointer, each log2(DEPTH) bits, wrap modulo DEPTH. Occupancy counter is log2(DEPTH)+1 bits.
- push = f_valid & f_ready & !flush.
- pop = d_valid & d_ready & !flush.
- f_ready = (count != DEPTH). Combinational from registered count only; never depends on d_ready (no full-bypass).
- d_valid = (count != 0).
- d_pc, d_instr and d_misaligned come from the entry at the read pointer. When count == 0 they are forced to 0.
- Latency: an entry pushed at edge N is visible on d_* after edge N. Minimum fetch-to-decode latency is 1 cycle. There is no combinational input-to-output path.
- Push only: write entry, advance write pointer, count+1.
- Pop only: advance read pointer, count-1.
- Push and pop in the same cycle: both pointers advance, count unchanged. This is legal when the queue is non-empty and not full.
- Full (count == DEPTH): f_ready = 0. f_valid is ignored and storage is not modified. Fetch holds its pair stable until accepted.
- Empty (count == 0): d_valid = 0, so d_ready is ignored and no pop occurs.
- Flush: at the next edge both pointers and count return to 0. Any push or pop that cycle is suppressed, including the pair on f_* during the flush cycle. d_valid is 0 in the cycle after the flush. Flush while empty has no effect. Flush has priority over all other events.
- Reset (reset_n low, at any time including mid-transfer): pointers = 0, count = 0, d_valid = 0, d_pc = 0, d_instr = 0, d_misaligned = 0, f_ready = 1. Storage contents need not be cleared. Operation resumes on the first rising edge after reset_n rises.
- f_pc is stored unmodified. misaligned = |f_pc[1:0] is captured at push.

Optional Feature:
- Macro IF_ID_QUEUE_PERF_EN.
- When defined: three extra output ports, all 32-bit, all saturating at 0xFFFFFFFF, all cleared by reset only (not by flush):
  - stall_full_cnt: increments every cycle where f_valid & !f_ready.
  - bubble_cnt: increments every cycle where d_ready & !d_valid.
  - flushed_cnt: adds the occupancy count at each flush.
- When not defined: the ports and counters do not exist, and all other behaviour is identical.

Test Plan:
1. Reset, then push pc 0x0, 0x4, 0x8 with d_ready = 1 continuously. Required: d_pc shows 0x0, 0x4, 0x8 on consecutive cycles, each one cycle after its push; d_valid drops the cycle after the last pop.
2. d_ready = 0, f_valid = 1 streaming from pc 0x10 with DEPTH = 2. Required: f_ready = 0 after two pushes; head stays 0x10. Raise d_ready: 0x10, 0x14, 0x18 are delivered in order with no loss or duplicate.
3. Queue holds 0x20, 0x24; assert flush for one cycle while f_pc = 0x28 is valid. Required: d_valid = 0 the next cycle. A following push of 0x100 appears as the next d_pc; 0x28 never appears.
4. Push f_pc = 0x32, then 0x34. Required: d_misaligned = 1 for 0x32 and 0 for 0x34.
5. Assert reset_n low asynchronously between edges while the queue is full. Required: d_valid, d_pc and d_instr go to 0 immediately and f_ready = 1. After release, the first push is delivered correctly with wrap-around pointers at 0.
6. With IF_ID_QUEUE_PERF_EN defined: 3 full-stall cycles, 2 bubble cycles, and a flush at occupancy 2. Required: stall_full_cnt = 3, bubble_cnt = 2, flushed_cnt = 2.
